// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises 12-bit DAC codes into 16-bit SPI frames
// ({ctrl nibble, code}, MSB first, SPI mode 0 timing with a lead-in
// half period after chip select falls and a gap after it rises).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for sample_valid; cs_n high, sclk low, mosi low
// LEAD   | cs_n low, first bit on mosi, one half period before sclk rises
// SHIFT  | 16 sclk periods; mosi advances on every falling sclk edge
// GAP    | cs_n high for two half periods; frame_done in first cycle
module dac_spi_tx #(
  parameter int         CLK_DIV   = 2,
  parameter logic [3:0] CTRL_BITS = 4'b0011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sample,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // Half-period reload value for the divider down-counter.
  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

  logic [1:0]  state;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] frame;

  // Ready is only offered from IDLE and never while reset is asserted.
  assign sample_ready = rst_n && (state == ST_IDLE);

  // Frame sequencer: state, counters, shift register and all pin outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      div_cnt    <= 8'd0;
      bit_cnt    <= 4'd0;
      frame      <= 16'd0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_mosi   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          dac_cs_n <= 1'b1;
          dac_sclk <= 1'b0;
          dac_mosi <= 1'b0;
          busy     <= 1'b0;
          bit_cnt  <= 4'd0;
          if (sample_valid) begin
            // The first bit goes out with chip select so it has a full
            // lead-in half period of setup before the first rising edge.
            frame    <= {CTRL_BITS, sample};
            dac_mosi <= CTRL_BITS[3];
            dac_cs_n <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= DIV_RELOAD;
            state    <= ST_LEAD;
          end
        end

        ST_LEAD: begin
          if (div_cnt == 8'd0) begin
            dac_sclk <= 1'b1;
            div_cnt  <= DIV_RELOAD;
            bit_cnt  <= 4'd0;
            state    <= ST_SHIFT;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end

        ST_SHIFT: begin
          if (div_cnt == 8'd0) begin
            div_cnt <= DIV_RELOAD;
            if (dac_sclk) begin
              // Falling edge: advance to the next bit; the last bit is
              // held through the final low phase. Rotating (rather than
              // shifting) keeps the register contents intact.
              dac_sclk <= 1'b0;
              if (bit_cnt != 4'd15) begin
                dac_mosi <= frame[14];
                frame    <= {frame[14:0], frame[15]};
              end
            end else if (bit_cnt == 4'd15) begin
              dac_cs_n   <= 1'b1;
              dac_mosi   <= 1'b0;
              frame_done <= 1'b1;
              bit_cnt    <= 4'd0;
              state      <= ST_GAP;
            end else begin
              dac_sclk <= 1'b1;
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end

        ST_GAP: begin
          // The gap is two half periods; bit_cnt marks which half we are
          // in so the 8-bit divider never needs to hold 2*CLK_DIV.
          if (div_cnt == 8'd0) begin
            div_cnt <= DIV_RELOAD;
            if (bit_cnt == 4'd0) begin
              bit_cnt <= 4'd1;
            end else begin
              bit_cnt <= 4'd0;
              div_cnt <= 8'd0;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: a CLK_DIV=2 instance driven from a vector table
// with a frame scoreboard, plus a CLK_DIV=1 instance checked by hand.
module tb_dac_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- DUT, CLK_DIV = 2 ----------------
  logic        rst2, valid2, ready2, cs2, sclk2, mosi2, busy2, done2;
  logic [11:0] sample2;

  dac_spi_tx #(.CLK_DIV(2)) u2 (
    .clk(clk), .rst_n(rst2), .sample(sample2), .sample_valid(valid2),
    .sample_ready(ready2), .dac_cs_n(cs2), .dac_sclk(sclk2),
    .dac_mosi(mosi2), .busy(busy2), .frame_done(done2)
  );

  // ---------------- DUT, CLK_DIV = 1 ----------------
  logic        rst1, valid1, ready1, cs1, sclk1, mosi1, busy1, done1;
  logic [11:0] sample1;

  dac_spi_tx #(.CLK_DIV(1)) u1 (
    .clk(clk), .rst_n(rst1), .sample(sample1), .sample_valid(valid1),
    .sample_ready(ready1), .dac_cs_n(cs1), .dac_sclk(sclk1),
    .dac_mosi(mosi1), .busy(busy1), .frame_done(done1)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] frame;
    int          acc;
  } sb_t;
  sb_t sb[$];

  bit abort_pending = 1'b0;
  int frames_seen = 0;

  // Frame monitor for u2: captures mosi on sclk rising edges, checks
  // timing relative to the accept cycle and compares against the queue.
  logic        p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
  logic [15:0] cap;
  int          rises, lowcnt, fell_cyc, first_rise;
  bit          in_frame = 1'b0;
  always @(negedge clk) begin
    sb_t e;
    bit  cs_rose;
    cs_rose = cs2 && !p_cs;
    if (!cs2 && p_cs) begin
      in_frame = 1'b1; cap = 16'd0; rises = 0; lowcnt = 0;
      fell_cyc = cyc; first_rise = -1;
    end
    if (!cs2) lowcnt++;
    if (in_frame && sclk2 && !p_sclk) begin
      cap = {cap[14:0], mosi2};
      rises++;
      if (first_rise < 0) first_rise = cyc;
    end
    if (!cs2 && !p_cs && (mosi2 != p_mosi) && !(p_sclk && !sclk2)) begin
      n_errors++;
      $display("FAIL mosi_change: moved off a falling sclk edge (cycle %0d)", cyc);
    end
    if (cs2 && sclk2) begin
      n_errors++;
      $display("FAIL sclk_idle: got 1 expected 0 while cs_n high (cycle %0d)", cyc);
    end
    if (done2 && !cs_rose) begin
      n_errors++;
      $display("FAIL frame_done_spurious: got 1 expected 0 (cycle %0d)", cyc);
    end
    if (cs_rose && in_frame) begin
      in_frame = 1'b0;
      if (abort_pending) begin
        abort_pending = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
        check("extra_frame", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        frames_seen++;
        check("frame_bits", 32'(cap), 32'(e.frame));
        check("sclk_rises", 32'(rises), 32'd16);
        check("cs_low_cycles", 32'(lowcnt), 32'd66);
        check("cs_fall_cycle", 32'(fell_cyc - e.acc), 32'd1);
        check("first_rise_cycle", 32'(first_rise - e.acc), 32'd3);
        check("cs_rise_cycle", 32'(cyc - e.acc), 32'd67);
        check("frame_done_pulse", 32'(done2), 32'd1);
      end
    end
    p_cs = cs2; p_sclk = sclk2; p_mosi = mosi2;
  end

  // Offer a sample on u2 and wait (bounded) for it to be accepted.
  task automatic send(input logic [11:0] s, input logic [15:0] exp,
                      output int acc, input bit keep_valid);
    int t = 0;
    sample2 = s;
    valid2  = 1'b1;
    @(negedge clk);
    while (!ready2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    acc = cyc;
    if (!ready2) check("accept_timeout", 32'd0, 32'd1);
    else sb.push_back('{frame: exp, acc: cyc});
    @(posedge clk);
    #1;
    if (!keep_valid) valid2 = 1'b0;
  endtask

  typedef struct {
    logic [11:0] sample;
    logic [15:0] frame;
    bit          pulse_mid;
  } vec_t;
  vec_t vec[5];

  initial begin
    int a1, a2, t;
    int low, rs, dn, back, bad, last_rise;
    logic [15:0] c1;
    logic ps;

    vec[0] = '{12'hA5C, 16'h3A5C, 1'b0};
    vec[1] = '{12'h000, 16'h3000, 1'b1};
    vec[2] = '{12'hFFF, 16'h3FFF, 1'b0};
    vec[3] = '{12'h800, 16'h3800, 1'b1};
    vec[4] = '{12'h123, 16'h3123, 1'b0};

    rst2 = 1'b0; valid2 = 1'b0; sample2 = 12'h0;
    rst1 = 1'b0; valid1 = 1'b1; sample1 = 12'hABC;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs2), 32'd1);
    check("rst_sclk", 32'(sclk2), 32'd0);
    check("rst_mosi", 32'(mosi2), 32'd0);
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_frame_done", 32'(done2), 32'd0);
    check("rst_ready", 32'(ready2), 32'd0);
    check("rst_no_accept_u1", 32'(cs1), 32'd1);
    valid1 = 1'b0;
    rst2 = 1'b1; rst1 = 1'b1;
    #1;
    check("ready_after_release", 32'(ready2), 32'd1);
    @(posedge clk);
    #1;

    // Table-driven frames, some with a stray mid-frame offer.
    for (int i = 0; i < 5; i++) begin
      send(vec[i].sample, vec[i].frame, a1, 1'b0);
      if (vec[i].pulse_mid) begin
        repeat (10) @(posedge clk);
        #1;
        sample2 = ~vec[i].sample;
        valid2  = 1'b1;
        @(negedge clk);
        check("ready_mid_frame", 32'(ready2), 32'd0);
        check("busy_mid_frame", 32'(busy2), 32'd1);
        @(posedge clk);
        #1;
        valid2 = 1'b0;
      end
    end

    // Back-to-back with valid held high.
    send(12'h000, 16'h3000, a1, 1'b1);
    send(12'hFFF, 16'h3FFF, a2, 1'b0);
    check("b2b_spacing", 32'(a2 - a1), 32'd71);

    // Reset in the high phase of bit 7, then a clean frame.
    send(12'hA5C, 16'h3A5C, a1, 1'b0);
    t = 0;
    while (cyc < a1 + 32 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("bit7_sclk_high", 32'(sclk2), 32'd1);
    abort_pending = 1'b1;
    rst2 = 1'b0;
    @(negedge clk);
    check("abort_cs_n", 32'(cs2), 32'd1);
    check("abort_sclk", 32'(sclk2), 32'd0);
    check("abort_busy", 32'(busy2), 32'd0);
    check("abort_mosi", 32'(mosi2), 32'd0);
    check("abort_ready", 32'(ready2), 32'd0);
    @(negedge clk);
    rst2 = 1'b1;
    #1;
    check("abort_ready_release", 32'(ready2), 32'd1);
    @(posedge clk);
    #1;
    send(12'h3C7, 16'h33C7, a1, 1'b0);

    // CLK_DIV = 1 frame, checked cycle by cycle.
    sample1 = 12'h800;
    valid1  = 1'b1;
    @(negedge clk);
    check("d1_ready", 32'(ready1), 32'd1);
    a1 = cyc;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    sample1 = 12'h7FF;
    low = 0; rs = 0; dn = 0; back = -1; bad = 0; last_rise = -1;
    c1 = 16'd0; ps = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (!cs1) low++;
      if (sclk1 && !ps) begin
        c1 = {c1[14:0], mosi1};
        rs++;
        if (last_rise >= 0 && cyc - last_rise != 2) bad++;
        last_rise = cyc;
      end
      if (done1) dn++;
      if (ready1 && back < 0) back = cyc - a1;
      ps = sclk1;
    end
    check("d1_cs_low", 32'(low), 32'd33);
    check("d1_rises", 32'(rs), 32'd16);
    check("d1_bits", 32'(c1), 32'h3800);
    check("d1_sclk_period", 32'(bad), 32'd0);
    check("d1_frame_done", 32'(dn), 32'd1);
    check("d1_ready_back", 32'(back), 32'd36);

    t = 0;
    while (sb.size() > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("frames_seen", 32'(frames_seen), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
